// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one external combinational FP adder among NREQ requesters.
// Operands are registered onto the adder, the sum is captured a cycle later and returned with its requester id.
module fp_add_scheduler #(
    parameter int XLEN = 32,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*XLEN-1:0] req_a,
    input  logic [NREQ*XLEN-1:0] req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [XLEN-1:0]      add_a,
    output logic [XLEN-1:0]      add_b,
    input  logic [XLEN-1:0]      add_result,
    output logic                 resp_valid,
    output logic [IDW-1:0]       resp_id,
    output logic [XLEN-1:0]      resp_data,
    input  logic                 resp_ready,
    output logic                 busy,
    output logic [15:0]          ops_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      state_q,     state_d;
    logic [IDW-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [IDW-1:0]  id_q,        id_d;
    logic [XLEN-1:0] add_a_q,     add_a_d;
    logic [XLEN-1:0] add_b_q,     add_b_d;
    logic [XLEN-1:0] resp_data_q, resp_data_d;
    logic [IDW-1:0]  resp_id_q,   resp_id_d;
    logic [15:0]     ops_done_q,  ops_done_d;

    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;

    // Search upward from rr_ptr, wrapping at NREQ-1; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IDW'((32'(rr_ptr_q) + i) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state_q == S_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        ops_done_d  = ops_done_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    add_a_d  = req_a[grant_idx*XLEN +: XLEN];
                    add_b_d  = req_b[grant_idx*XLEN +: XLEN];
                    id_d     = grant_idx;
                    rr_ptr_d = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                resp_data_d = add_result;
                resp_id_d   = id_q;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    ops_done_d = ops_done_q + 16'd1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            resp_data_q <= '0;
            resp_id_q   <= '0;
            ops_done_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign ops_done   = ops_done_q;
    assign resp_valid = (state_q == S_RESP);
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed bench for fp_add_scheduler; a small lookup-based adder stands in for the external FP adder.
module tb_fp_add_scheduler;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ready;
    logic [31:0]  add_a;
    logic [31:0]  add_b;
    logic [31:0]  add_result;
    logic         resp_valid;
    logic [1:0]   resp_id;
    logic [31:0]  resp_data;
    logic         resp_ready;
    logic         busy;
    logic [15:0]  ops_done;

    int tests_run;
    int tests_failed;

    fp_add_scheduler #(.XLEN(32), .NREQ(4), .IDW(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Only the operand pairs used below are modelled; zero operands yield zero.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h0 || b == 32'h0) return 32'h0;
        if (a == 32'h3FC00000 && b == 32'h3FC00000) return 32'h40400000;
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return a ^ b;
    endfunction

    assign add_result = fadd(add_a, add_b);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 4'hF;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 32'h3F800000, 32'h40000000);
        tick();
        tick();
        tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
        tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests_run++; if (ops_done !== 16'h0) begin tests_failed++; $display("FAIL reset_ops_done got %h exp 0000", ops_done); end
        tests_run++; if (add_a !== 32'h0 || resp_data !== 32'h0) begin tests_failed++; $display("FAIL reset_regs got add_a=%h resp_data=%h exp 0", add_a, resp_data); end
        rst_n = 1'b1;
        #1;
        tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL reset_first_grant got %b exp 0001", req_ready); end
        tick();
        req_valid = 4'h0;
        tests_run++; if (busy !== 1'b1 || add_a !== 32'h3F800000) begin tests_failed++; $display("FAIL reset_exec got busy=%b add_a=%h exp 1/3f800000", busy, add_a); end
        tick();
        tick();
    endtask

    task automatic test_single_op();
        do_reset();
        resp_ready = 1'b1;
        req_valid = 4'b0100;
        set_req(2, 32'h3FC00000, 32'h3FC00000);
        #1;
        tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL single_grant got %b exp 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        #1;
        tests_run++; if (busy !== 1'b1 || resp_valid !== 1'b0 || req_ready !== 4'b0000) begin tests_failed++; $display("FAIL single_exec got busy=%b rv=%b rr=%b exp 1/0/0000", busy, resp_valid, req_ready); end
        tests_run++; if (add_a !== 32'h3FC00000 || add_b !== 32'h3FC00000) begin tests_failed++; $display("FAIL single_operands got %h %h exp 3fc00000", add_a, add_b); end
        tick();
        tests_run++; if (resp_valid !== 1'b1 || resp_data !== 32'h40400000 || resp_id !== 2'd2) begin tests_failed++; $display("FAIL single_resp got rv=%b data=%h id=%0d exp 1/40400000/2", resp_valid, resp_data, resp_id); end
        tests_run++; if (ops_done !== 16'd0) begin tests_failed++; $display("FAIL single_ops_before got %0d exp 0", ops_done); end
        tick();
        tests_run++; if (ops_done !== 16'd1 || resp_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL single_done got ops=%0d rv=%b busy=%b exp 1/0/0", ops_done, resp_valid, busy); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id;
        logic [3:0] exp_rdy;
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 32'h3F800000, 32'h40000000);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            exp_id = 2'(k % 4);
            exp_rdy = 4'b0001 << exp_id;
            #1;
            tests_run++; if (req_ready !== exp_rdy || resp_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_grant%0d got %b rv=%b exp %b/0", k, req_ready, resp_valid, exp_rdy); end
            tick();
            tests_run++; if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin tests_failed++; $display("FAIL rr_exec%0d got rr=%b rv=%b exp 0000/0", k, req_ready, resp_valid); end
            tick();
            tests_run++; if (resp_valid !== 1'b1 || resp_id !== exp_id || resp_data !== 32'h40400000 || req_ready !== 4'b0000) begin tests_failed++; $display("FAIL rr_resp%0d got rv=%b id=%0d data=%h rr=%b exp 1/%0d/40400000/0000", k, resp_valid, resp_id, resp_data, req_ready, exp_id); end
            tick();
        end
        req_valid = 4'h0;
        #1;
        tests_run++; if (ops_done !== 16'd5) begin tests_failed++; $display("FAIL rr_ops_done got %0d exp 5", ops_done); end
    endtask

    task automatic test_backpressure();
        do_reset();
        resp_ready = 1'b0;
        set_req(1, 32'h3F800000, 32'h40000000);
        set_req(3, 32'h3FC00000, 32'h3FC00000);
        req_valid = 4'b1010;
        #1;
        tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL bp_grant got %b exp 0010", req_ready); end
        tick();
        req_valid = 4'b1000;
        tick();
        for (int c = 0; c < 10; c++) begin
            tests_run++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 32'h40400000 || busy !== 1'b1 || req_ready !== 4'b0000) begin tests_failed++; $display("FAIL bp_hold%0d got rv=%b id=%0d data=%h busy=%b rr=%b exp 1/1/40400000/1/0000", c, resp_valid, resp_id, resp_data, busy, req_ready); end
            tick();
        end
        tests_run++; if (ops_done !== 16'd0) begin tests_failed++; $display("FAIL bp_ops_stalled got %0d exp 0", ops_done); end
        resp_ready = 1'b1;
        tick();
        tests_run++; if (ops_done !== 16'd1 || resp_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_release got ops=%0d rv=%b exp 1/0", ops_done, resp_valid); end
        tests_run++; if (req_ready !== 4'b1000) begin tests_failed++; $display("FAIL bp_next_grant got %b exp 1000", req_ready); end
        req_valid = 4'h0;
        tick();
        tests_run++; if (ops_done !== 16'd1 || busy !== 1'b0) begin tests_failed++; $display("FAIL bp_once got ops=%0d busy=%b exp 1/0", ops_done, busy); end
    endtask

    task automatic test_zero_passthrough();
        do_reset();
        resp_ready = 1'b1;
        set_req(0, 32'h00000000, 32'h40000000);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0000;
        tick();
        tests_run++; if (resp_valid !== 1'b1 || resp_data !== 32'h00000000 || resp_id !== 2'd0) begin tests_failed++; $display("FAIL zero_resp got rv=%b data=%h id=%0d exp 1/00000000/0", resp_valid, resp_data, resp_id); end
        tick();
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 32'h3F800000, 32'h40000000);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        req_valid = 4'b1100;
        #1;
        tests_run++; if (ops_done !== 16'd1 || req_ready !== 4'b0100) begin tests_failed++; $display("FAIL mid_pre got ops=%0d rr=%b exp 1/0100", ops_done, req_ready); end
        tick();
        rst_n = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0 || resp_valid !== 1'b0 || ops_done !== 16'd0 || req_ready !== 4'b0000 || add_a !== 32'h0) begin tests_failed++; $display("FAIL mid_reset got busy=%b rv=%b ops=%0d rr=%b add_a=%h exp 0/0/0/0000/0", busy, resp_valid, ops_done, req_ready, add_a); end
        tick();
        tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_no_resp got %b exp 0", resp_valid); end
        rst_n = 1'b1;
        #1;
        tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL mid_regrant got %b exp 0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        tests_run++; if (resp_valid !== 1'b1 || resp_id !== 2'd2) begin tests_failed++; $display("FAIL mid_resp got rv=%b id=%0d exp 1/2", resp_valid, resp_id); end
        tick();
        tests_run++; if (ops_done !== 16'd1) begin tests_failed++; $display("FAIL mid_ops got %0d exp 1", ops_done); end
    endtask

    task automatic test_ops_wrap();
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 32'h3F800000, 32'h40000000);
        req_valid = 4'hF;
        for (int n = 0; n < 65535; n++) begin
            tick();
            tick();
            tick();
        end
        tests_run++; if (ops_done !== 16'hFFFF) begin tests_failed++; $display("FAIL wrap_max got %h exp ffff", ops_done); end
        tick();
        tick();
        tick();
        req_valid = 4'h0;
        tests_run++; if (ops_done !== 16'h0000) begin tests_failed++; $display("FAIL wrap_zero got %h exp 0000", ops_done); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b0;
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_zero_passthrough();
        test_reset_mid_exec();
        test_ops_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
